sel8_rr_arbiter: RTL and testbench
==================================

// Module: sel8_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8:1 select datapath between 8 requesters.
//  Drives the 3 mux select lines and a one-hot grant vector.
//  Holds each grant until the owner drops its request, then inserts a 1-cycle dead gap.
//  Sits beside the 8:1 mux tree: sel[2] -> s1, sel[1] -> s2, sel[0] -> s3; index 0 = input a1.
// PARAMETERS
//  MAX_HOLD  16  max consecutive GRANT cycles per owner (used only with SEL8_TIMEOUT_EN); legal 2..255
//  LAST_RST  7   reset value of last-owner pointer (7 => requester 0 wins first)
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  en       in   1  1 = new grants allowed; 0 = no new grant (current grant unaffected)
//  req      in   8  request per requester; held high for the whole transfer
//  gnt      out  8  one-hot grant, registered; all-zero when no owner
//  sel      out  3  registered mux select = owner index
//  busy     out  1  1 while state == GRANT
//  tmo      out  1  1-cycle pulse on forced release (SEL8_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, gnt=0, sel=0, busy=0, tmo=0, last=LAST_RST, hold_cnt=0.
//  - States: IDLE, GRANT, GAP.
//  - IDLE: if en && |req -> GRANT next edge; winner = first set bit scanning
//    last+1, last+2, ... (mod 8); gnt/sel/busy valid the cycle after req seen (latency 1).
//  - GRANT: stays while req[owner]=1; req of others ignored; en ignored.
//    req[owner]=0 -> GAP next edge, gnt=0, busy=0, last=owner.
//  - GAP: exactly 1 cycle, gnt=0, sel holds previous owner; then IDLE-arbitration
//    rules apply same cycle (GAP -> GRANT directly if en && |req, else IDLE).
//  - Pointer update on release only; recently served requester gets lowest priority.
//  - Same requester re-requesting alone after GAP is re-granted (no starvation of lone user).
//  - Worst-case wait for a continuously asserted req: 7 transfers + 7 gaps.
//  - req glitch of owner low for 1 cycle ends the grant; no re-acquire without arbitration.
//  - rst mid-GRANT: gnt drops on that edge, pointer back to LAST_RST.
//  - gnt always one-hot or zero; sel changes only on entry to GRANT.
// CONFIGURATION
//  SEL8_TIMEOUT_EN defined: hold_cnt (8 bit) counts GRANT cycles; when it reaches
//   MAX_HOLD while req[owner]=1 -> forced release to GAP, tmo=1 for that GAP cycle,
//   last=owner; owner must re-arbitrate.
//  Undefined: no counter, grant unbounded, tmo constant 0.
// STRUCTURE
//  - Shared header sel8_defs.vh: state encodings (IDLE=2'd0, GRANT=2'd1, GAP=2'd2),
//    N_REQ=8, SEL_W=3.
//  - One sub-module: sel8_rr_pick (combinational: req[7:0], last[2:0] -> valid, idx[2:0]),
//    rotate-priority encoder; instantiated once.
//  - State, owner, last, hold_cnt registers in top.
// TESTING
//  1) rst, req=8'h01, en=1 -> cycle+1 gnt=8'h01 sel=0 busy=1; drop req -> gnt=0 next, GAP 1 cycle.
//  2) req=8'hFF held -> grants 0,1,2,...,7,0 in order, each separated by one GAP cycle.
//  3) owner 3, req=8'h28 after release -> next grant idx 5, then 3 (rotation from last=3).
//  4) en=0, req=8'h10 -> gnt stays 0; en=1 -> grant idx 4 next cycle; en=0 mid-grant -> grant kept.
//  5) rst asserted mid-GRANT (owner 6) -> gnt=0, sel=0 next edge; req=8'hC0 -> idx 6 wins (last=7).
//  6) SEL8_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held -> owner 0 for 4 cycles, tmo pulse, then owner 1.

Source files
------------

// File: rtl/sel8_rr_arbiter_pkg.sv
// Shared types and constants for the sel8 round-robin arbiter.
package sel8_rr_arbiter_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Registered arbiter outputs, kept together so they update as one word
    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [SEL_W-1:0] sel;
        logic             busy;
        logic             tmo;
    } arb_out_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/sel8_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface sel8_rr_arbiter_if;
    import sel8_rr_arbiter_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             tmo;

    modport master (output en, req, input gnt, sel, busy, tmo);
    modport slave  (input en, req, output gnt, sel, busy, tmo);

endinterface

// File: rtl/sel8_rr_pick.sv
// Rotating-priority encoder: first set request scanning last+1, last+2, ... (mod 8).
module sel8_rr_pick
    import sel8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic             valid_c,
    output logic [SEL_W-1:0] idx_c
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest offset down so the nearest requester overwrites last
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = last_i + SEL_W'(i);
            if (req_i[cand]) begin
                valid_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/sel8_rr_arbiter.sv
// Round-robin arbiter for an 8:1 select datapath with a 1-cycle dead gap between owners.
// Optional grant time limit enabled by defining SEL8_TIMEOUT_EN.
module sel8_rr_arbiter
    import sel8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned LAST_RST = 7
) (
    input  logic              clk,
    input  logic              rst,
    sel8_rr_arbiter_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("sel8_rr_arbiter: MAX_HOLD must be in 2..255");
    end
    if (LAST_RST >= N_REQ) begin : g_bad_last_rst
        $error("sel8_rr_arbiter: LAST_RST must be below N_REQ");
    end

    state_e           state_q, state_d;
    arb_out_t         out_q, out_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             rel;
`ifdef SEL8_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    sel8_rr_pick u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            last_q  <= SEL_W'(LAST_RST);
`ifdef SEL8_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            last_q  <= last_d;
`ifdef SEL8_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_d.tmo = 1'b0;
        last_d    = last_q;
        rel       = 1'b0;
`ifdef SEL8_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            // GAP arbitrates exactly like IDLE, so back-to-back transfers cost one dead cycle
            ST_IDLE, ST_GAP: begin
                if (bus.en && pick_valid) begin
                    state_d    = ST_GRANT;
                    out_d.gnt  = onehot(pick_idx);
                    out_d.sel  = pick_idx;
                    out_d.busy = 1'b1;
`ifdef SEL8_TIMEOUT_EN
                    hold_d     = HOLD_W'(1);
`endif
                end else begin
                    state_d    = ST_IDLE;
                    out_d.gnt  = '0;
                    out_d.busy = 1'b0;
                end
            end
            ST_GRANT: begin
                rel = !bus.req[out_q.sel];
`ifdef SEL8_TIMEOUT_EN
                hold_d = hold_q + HOLD_W'(1);
                if (!rel && hold_q == HOLD_W'(MAX_HOLD)) begin
                    rel       = 1'b1;
                    out_d.tmo = 1'b1;
                end
`endif
                if (rel) begin
                    state_d    = ST_GAP;
                    out_d.gnt  = '0;
                    out_d.busy = 1'b0;
                    last_d     = out_q.sel;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                out_d.gnt  = '0;
                out_d.busy = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = out_q.gnt;
    assign bus.sel  = out_q.sel;
    assign bus.busy = out_q.busy;
    assign bus.tmo  = out_q.tmo;

endmodule

// File: tb/tb_sel8_rr_arbiter.sv
// Directed bench for sel8_rr_arbiter; expected outputs queued per step and checked after the edge.
module tb_sel8_rr_arbiter;
    import sel8_rr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sel8_rr_arbiter_if bus();

    sel8_rr_arbiter #(
        .MAX_HOLD (4),
        .LAST_RST (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_step   = 0;

    function automatic logic [7:0] oh(input int i);
        logic [7:0] v;
        v = 8'h01 << i;
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s step %0d: observed %h expected %h", tag, fld, n_step, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then check them
    task automatic step(input logic r, input logic e, input logic [7:0] rq,
                        input logic [7:0] eg, input logic [2:0] es, input logic eb,
                        input logic et, input string tag);
        exp_t x;
        rst     = r;
        bus.en  = e;
        bus.req = rq;
        x.gnt = eg; x.sel = es; x.busy = eb; x.tmo = et;
        sb.push_back(x);
        @(posedge clk);
        #1;
        n_step++;
        x = sb.pop_front();
        chk(tag, "gnt",  bus.gnt,              x.gnt);
        chk(tag, "sel",  {5'd0, bus.sel},      {5'd0, x.sel});
        chk(tag, "busy", {7'd0, bus.busy},     {7'd0, x.busy});
        chk(tag, "tmo",  {7'd0, bus.tmo},      {7'd0, x.tmo});
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.req = 8'h00;

        // Reset state, reset dominating live requests
        step(1, 0, 8'h00, 8'h00, 0, 0, 0, "rst");
        step(1, 1, 8'hFF, 8'h00, 0, 0, 0, "rst_dom");

        // Single requester: latency 1, hold, one gap, back to idle
        step(0, 1, 8'h01, 8'h01, 0, 1, 0, "t1_grant");
        step(0, 1, 8'h01, 8'h01, 0, 1, 0, "t1_hold");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "t1_gap");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "t1_idle");

        // Lone requester is re-granted straight out of the gap
        step(0, 1, 8'h01, 8'h01, 0, 1, 0, "lone_grant");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "lone_gap");
        step(0, 1, 8'h01, 8'h01, 0, 1, 0, "lone_regrant");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "lone_gap2");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "lone_idle");

        // Full rotation 0..7,0 with everybody requesting; owner drops its bit for one cycle
        step(1, 0, 8'h00, 8'h00, 0, 0, 0, "t2_rst");
        for (int k = 0; k <= 8; k++) begin
            step(0, 1, 8'hFF,          oh(k % 8), 3'(k % 8), 1, 0, "t2_grant");
            step(0, 1, 8'hFF,          oh(k % 8), 3'(k % 8), 1, 0, "t2_hold");
            step(0, 1, 8'hFF & ~oh(k % 8), 8'h00, 3'(k % 8), 0, 0, "t2_gap");
        end

        // Rotation from last=3: 5 before 3
        step(0, 1, 8'h08, oh(3), 3, 1, 0, "t3_own3");
        step(0, 1, 8'h08, oh(3), 3, 1, 0, "t3_hold3");
        step(0, 1, 8'h20, 8'h00, 3, 0, 0, "t3_gap");
        step(0, 1, 8'h28, oh(5), 5, 1, 0, "t3_own5");
        step(0, 1, 8'h28, oh(5), 5, 1, 0, "t3_hold5");
        step(0, 1, 8'h08, 8'h00, 5, 0, 0, "t3_gap5");
        step(0, 1, 8'h08, oh(3), 3, 1, 0, "t3_own3b");
        step(0, 1, 8'h00, 8'h00, 3, 0, 0, "t3_gap3");
        step(0, 1, 8'h00, 8'h00, 3, 0, 0, "t3_idle");

        // Enable gating: blocks new grants only
        step(0, 0, 8'h10, 8'h00, 3, 0, 0, "t4_en0_a");
        step(0, 0, 8'h10, 8'h00, 3, 0, 0, "t4_en0_b");
        step(0, 1, 8'h10, oh(4), 4, 1, 0, "t4_grant4");
        step(0, 0, 8'h10, oh(4), 4, 1, 0, "t4_kept_a");
        step(0, 0, 8'h10, oh(4), 4, 1, 0, "t4_kept_b");
        step(0, 0, 8'h01, 8'h00, 4, 0, 0, "t4_gap");
        step(0, 0, 8'h01, 8'h00, 4, 0, 0, "t4_gap_en0");
        step(0, 1, 8'h01, oh(0), 0, 1, 0, "t4_grant0");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "t4_gap0");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "t4_idle");

        // Reset mid-grant returns the pointer to 7
        step(0, 1, 8'h40, oh(6), 6, 1, 0, "t5_own6");
        step(0, 1, 8'h40, oh(6), 6, 1, 0, "t5_hold6");
        step(1, 1, 8'h40, 8'h00, 0, 0, 0, "t5_rst_mid");
        step(0, 1, 8'hC0, oh(6), 6, 1, 0, "t5_win6");
        step(0, 1, 8'h80, 8'h00, 6, 0, 0, "t5_gap");
        step(0, 1, 8'h80, oh(7), 7, 1, 0, "t5_own7");
        step(0, 1, 8'h00, 8'h00, 7, 0, 0, "t5_gap7");
        step(0, 1, 8'h00, 8'h00, 7, 0, 0, "t5_idle");

`ifdef SEL8_TIMEOUT_EN
        // Forced release after MAX_HOLD=4 grant cycles
        step(1, 0, 8'h00, 8'h00, 0, 0, 0, "t6_rst");
        for (int k = 0; k < 4; k++)
            step(0, 1, 8'h03, oh(0), 0, 1, 0, "t6_own0");
        step(0, 1, 8'h03, 8'h00, 0, 0, 1, "t6_tmo");
        step(0, 1, 8'h03, oh(1), 1, 1, 0, "t6_own1");
        step(0, 1, 8'h01, 8'h00, 1, 0, 0, "t6_gap1");
        step(0, 1, 8'h01, oh(0), 0, 1, 0, "t6_own0b");
        step(0, 1, 8'h00, 8'h00, 0, 0, 0, "t6_gap0");
`else
        // Without the time limit a grant is unbounded and tmo never pulses
        step(1, 0, 8'h00, 8'h00, 0, 0, 0, "t6_rst");
        for (int k = 0; k < 6; k++)
            step(0, 1, 8'h03, oh(0), 0, 1, 0, "t6_unbounded");
        step(0, 1, 8'h02, 8'h00, 0, 0, 0, "t6_gap");
        step(0, 1, 8'h02, oh(1), 1, 1, 0, "t6_own1");
        step(0, 1, 8'h00, 8'h00, 1, 0, 0, "t6_gap1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
